// File: rtl/reu_dma_engine.sv
// reu_dma_engine: REU transfer sequencer (initiator side of the dma_* toggle handshake).
//
// Moves bytes between C64 address space (through bus_manager's toggle handshake)
// and external REU RAM (level request / pulse acknowledge). Four commands:
// stash (C64->REU), fetch (REU->C64), swap and verify. Each byte runs a short
// access sequence followed by a STEP that advances the addresses and counter.
//
// State table:
//   state  | meaning
//   SYNC   | after reset: wait until dma_ack matches dma_req
//   IDLE   | not busy; accept start
//   C64_RD | C64 read through bus_manager (result -> byte_a)
//   C64_WR | C64 write through bus_manager
//   MEM_RD | REU RAM read (result -> byte_b)
//   MEM_WR | REU RAM write
//   CMP    | verify: compare byte_a with byte_b
//   STEP   | advance addresses, decrement remaining
//   FIN    | one-cycle done pulse
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   start, cmd, c64_addr, reu_addr,
//   length, fix_c64, fix_reu        transfer setup, latched on an accepted start
//   busy, done, verify_err          status
//   cur_c64_addr, cur_reu_addr,
//   remaining                       live transfer pointers for register readback
//   dma_a, dma_d, dma_q, dma_rw,
//   dma_req, dma_ack                C64 DMA cycle, toggle handshake
//   mem_a, mem_d, mem_q, mem_we,
//   mem_req, mem_ack                REU RAM port, level request / pulse ack
module reu_dma_engine #(
    parameter int REU_ADDR_BITS = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               cmd,
    input  logic [15:0]              c64_addr,
    input  logic [REU_ADDR_BITS-1:0] reu_addr,
    input  logic [15:0]              length,
    input  logic                     fix_c64,
    input  logic                     fix_reu,
    output logic                     busy,
    output logic                     done,
    output logic                     verify_err,
    output logic [15:0]              cur_c64_addr,
    output logic [REU_ADDR_BITS-1:0] cur_reu_addr,
    output logic [16:0]              remaining,
    output logic [15:0]              dma_a,
    output logic [7:0]               dma_d,
    input  logic [7:0]               dma_q,
    output logic                     dma_rw,
    output logic                     dma_req,
    input  logic                     dma_ack,
    output logic [REU_ADDR_BITS-1:0] mem_a,
    output logic [7:0]               mem_d,
    input  logic [7:0]               mem_q,
    output logic                     mem_we,
    output logic                     mem_req,
    input  logic                     mem_ack
);

    localparam logic [1:0] CMD_STASH  = 2'b00;
    localparam logic [1:0] CMD_FETCH  = 2'b01;
    localparam logic [1:0] CMD_SWAP   = 2'b10;
    localparam logic [1:0] CMD_VERIFY = 2'b11;

    localparam logic [REU_ADDR_BITS-1:0] REU_ONE = {{(REU_ADDR_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_SYNC,
        S_IDLE,
        S_C64_RD,
        S_C64_WR,
        S_MEM_RD,
        S_MEM_WR,
        S_CMP,
        S_STEP,
        S_FIN
    } state_t;

    state_t state, state_nx;

    logic [1:0]               cmd_q;
    logic                     fix_c64_q;
    logic                     fix_reu_q;
    logic [7:0]               byte_a;
    logic [7:0]               byte_b;
    logic                     dma_issued;
    logic                     dma_done;
    logic                     mem_done;
    logic                     enter;
    logic [15:0]              c64_inc;
    logic [15:0]              c64_src;
    logic [REU_ADDR_BITS-1:0] reu_inc;
    logic [REU_ADDR_BITS-1:0] reu_src;

    function automatic state_t first_state(input logic [1:0] c);
        return (c == CMD_FETCH) ? S_MEM_RD : S_C64_RD;
    endfunction

    // dma_issued separates "not yet toggled" from "toggled and acknowledged";
    // both look like dma_ack == dma_req.
    assign dma_done = dma_issued && (dma_ack == dma_req);
    assign mem_done = mem_req && mem_ack;
    assign c64_inc  = fix_c64_q ? cur_c64_addr : cur_c64_addr + 16'd1;
    assign reu_inc  = fix_reu_q ? cur_reu_addr : cur_reu_addr + REU_ONE;
    assign enter    = (state_nx != state);

    // Address presented by the access being entered: the start inputs when
    // leaving IDLE, the advanced pointers when leaving STEP.
    always_comb begin
        c64_src = cur_c64_addr;
        reu_src = cur_reu_addr;
        case (state)
            S_IDLE: begin
                c64_src = c64_addr;
                reu_src = reu_addr;
            end
            S_STEP: begin
                c64_src = c64_inc;
                reu_src = reu_inc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_SYNC;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        done     = 1'b0;
        case (state)
            S_SYNC: begin
                if (dma_ack == dma_req) state_nx = S_IDLE;
            end
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = first_state(cmd);
            end
            S_C64_RD: begin
                if (dma_done) state_nx = (cmd_q == CMD_STASH) ? S_MEM_WR : S_MEM_RD;
            end
            S_C64_WR: begin
                if (dma_done) state_nx = S_STEP;
            end
            S_MEM_RD: begin
                if (mem_done) begin
                    case (cmd_q)
                        CMD_FETCH: state_nx = S_C64_WR;
                        CMD_SWAP:  state_nx = S_MEM_WR;
                        default:   state_nx = S_CMP;
                    endcase
                end
            end
            S_MEM_WR: begin
                if (mem_done) state_nx = (cmd_q == CMD_SWAP) ? S_C64_WR : S_STEP;
            end
            S_CMP: begin
                state_nx = (byte_a != byte_b) ? S_FIN : S_STEP;
            end
            S_STEP: begin
                state_nx = (remaining == 17'd1) ? S_FIN : first_state(cmd_q);
            end
            S_FIN: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_SYNC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q        <= CMD_STASH;
            fix_c64_q    <= 1'b0;
            fix_reu_q    <= 1'b0;
            verify_err   <= 1'b0;
            cur_c64_addr <= '0;
            cur_reu_addr <= '0;
            remaining    <= '0;
            byte_a       <= '0;
            byte_b       <= '0;
            dma_a        <= '0;
            dma_d        <= '0;
            dma_rw       <= 1'b1;
            dma_req      <= 1'b0;
            dma_issued   <= 1'b0;
            mem_a        <= '0;
            mem_d        <= '0;
            mem_we       <= 1'b0;
            mem_req      <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                cmd_q        <= cmd;
                fix_c64_q    <= fix_c64;
                fix_reu_q    <= fix_reu;
                cur_c64_addr <= c64_addr;
                cur_reu_addr <= reu_addr;
                remaining    <= (length == 16'd0) ? 17'h10000 : {1'b0, length};
                verify_err   <= 1'b0;
            end

            if (state == S_STEP) begin
                remaining    <= remaining - 17'd1;
                cur_c64_addr <= c64_inc;
                cur_reu_addr <= reu_inc;
            end

            if (state == S_CMP && byte_a != byte_b) verify_err <= 1'b1;

            // Address/data were set on state entry; the toggle follows one cycle later.
            if ((state == S_C64_RD || state == S_C64_WR) && !dma_issued) begin
                dma_req    <= ~dma_req;
                dma_issued <= 1'b1;
            end
            if (dma_done) begin
                dma_issued <= 1'b0;
                if (state == S_C64_RD) byte_a <= dma_q;
            end

            // mem_req rises on the first cycle in a MEM state, so it is low for at
            // least one cycle between back-to-back REU accesses.
            if ((state == S_MEM_RD || state == S_MEM_WR) && !mem_req) mem_req <= 1'b1;
            if (mem_done) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                if (state == S_MEM_RD) byte_b <= mem_q;
            end

            // Entry loads come last so they win over the completion clears above.
            // Data captured in the same cycle is forwarded straight from the port.
            if (enter && state_nx == S_C64_RD) begin
                dma_a  <= c64_src;
                dma_rw <= 1'b1;
            end
            if (enter && state_nx == S_C64_WR) begin
                dma_a  <= c64_src;
                dma_rw <= 1'b0;
                dma_d  <= (state == S_MEM_RD) ? mem_q : byte_b;
            end
            if (enter && state_nx == S_MEM_RD) begin
                mem_a  <= reu_src;
                mem_we <= 1'b0;
            end
            if (enter && state_nx == S_MEM_WR) begin
                mem_a  <= reu_src;
                mem_we <= 1'b1;
                mem_d  <= (state == S_C64_RD) ? dma_q : byte_a;
            end
        end
    end

endmodule
